mc_control_unit: RTL and testbench

Multi-cycle control unit, directly upstream of the datapath. It fetches and latches the 24-bit instruction, decodes it, and sequences the datapath control strobes (regWrite, aluSrc, PCSrc, immSrc, memToReg, memWrite, ra2Src, aluControl). It adds handshakes to instruction and data memory, a PC write enable, and a sticky error state for illegal encodings and memory timeouts.

---
 rtl/cu_pkg.sv | 35 +++
 rtl/cu_decoder.sv | 25 ++
 rtl/mc_control_unit.sv | 161 ++++++++++++++++
 tb/tb_mc_control_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared types and encodings for the multi-cycle control unit
package cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERROR  = 3'd6
  } cu_state_e;

  localparam logic [1:0] CLS_DP_REG = 2'b00;
  localparam logic [1:0] CLS_DP_IMM = 2'b01;
  localparam logic [1:0] CLS_MEM    = 2'b10;
  localparam logic [1:0] CLS_BR     = 2'b11;

  localparam logic [1:0] BR_ALWAYS  = 2'b00;
  localparam logic [1:0] BR_EQ      = 2'b01;
  localparam logic [1:0] BR_NE      = 2'b10;
  localparam logic [1:0] BR_ILLEGAL = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;

  function automatic logic br_taken(input logic [1:0] cond, input logic zero);
    case (cond)
      BR_ALWAYS: br_taken = 1'b1;
      BR_EQ:     br_taken = zero;
      BR_NE:     br_taken = ~zero;
      default:   br_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - combinational field decode of the latched instruction
module cu_decoder
  import cu_pkg::*;
(
  input  logic [23:0] ir_i,
  output logic [1:0]  cls_o,
  output logic        is_load_o,
  output logic [1:0]  br_cond_o,
  output logic [1:0]  alu_op_o,
  output logic        illegal_o
);

  // The low 20 bits carry the immediate, which only the datapath consumes.
  logic unused_imm;
  assign unused_imm = ^ir_i[19:0];

  assign cls_o     = ir_i[23:22];
  assign is_load_o = ir_i[20];
  assign br_cond_o = ir_i[21:20];
  assign alu_op_o  = ir_i[21:20];

  assign illegal_o = ((ir_i[23:22] == CLS_MEM) && ir_i[21])
                   || ((ir_i[23:22] == CLS_BR) && (ir_i[21:20] == BR_ILLEGAL));

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle fetch/decode/execute sequencer with memory handshakes
module mc_control_unit
  import cu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] inst,
  input  logic        instValid,
  input  logic        cero,
  input  logic        memReady,
  output logic        instReq,
  output logic        memReq,
  output logic        pcWrite,
  output logic        regWrite,
  output logic        aluSrc,
  output logic        PCSrc,
  output logic        immSrc,
  output logic        memToReg,
  output logic        memWrite,
  output logic        ra2Src,
  output logic [1:0]  aluControl,
  output logic        err,
  output logic [2:0]  state
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  cu_state_e        state_q, state_d;
  logic [23:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] cls;
  logic       is_load;
  logic [1:0] br_cond;
  logic [1:0] alu_op;
  logic       illegal;
  logic       is_dp;

  cu_decoder u_dec (
    .ir_i      (ir_q),
    .cls_o     (cls),
    .is_load_o (is_load),
    .br_cond_o (br_cond),
    .alu_op_o  (alu_op),
    .illegal_o (illegal)
  );

  assign is_dp = ~cls[1];

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (instValid) begin
          ir_d    = inst;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = illegal ? ST_ERROR : ST_EXEC;
      ST_EXEC: begin
        if (cls == CLS_MEM) begin
          cnt_d   = '0;
          state_d = ST_MEM;
        end else if (cls == CLS_BR) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        // A response on the limit cycle still completes the access.
        if (memReady) begin
          state_d = is_load ? ST_WB : ST_FETCH;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB:     state_d = ST_FETCH;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instReq    = 1'b0;
    memReq     = 1'b0;
    pcWrite    = 1'b0;
    regWrite   = 1'b0;
    aluSrc     = 1'b0;
    PCSrc      = 1'b0;
    immSrc     = 1'b0;
    memToReg   = 1'b0;
    memWrite   = 1'b0;
    ra2Src     = 1'b0;
    aluControl = 2'b00;
    err        = 1'b0;
    case (state_q)
      ST_FETCH: instReq = 1'b1;
      ST_EXEC: begin
        if (cls == CLS_MEM) begin
          aluSrc     = 1'b1;
          immSrc     = 1'b1;
          aluControl = ALU_ADD;
        end else if (cls == CLS_BR) begin
          pcWrite = 1'b1;
          PCSrc   = br_taken(br_cond, cero);
          aluSrc  = 1'b1;
          immSrc  = 1'b1;
        end else begin
          aluSrc     = cls[0];
          aluControl = alu_op;
        end
      end
      ST_MEM: begin
        memReq = 1'b1;
        aluSrc = 1'b1;
        immSrc = 1'b1;
        if (!is_load) begin
          memWrite = 1'b1;
          ra2Src   = 1'b1;
          pcWrite  = memReady;
        end
      end
      ST_WB: begin
        // memToReg=1 picks the ALU result, so only DP sets it.
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        if (is_dp) begin
          memToReg   = 1'b1;
          aluSrc     = cls[0];
          aluControl = alu_op;
        end
      end
      ST_ERROR: err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - scoreboard bench for mc_control_unit
module tb_mc_control_unit;
  import cu_pkg::*;

  localparam logic [15:0] O_IREQ = 16'h8000;
  localparam logic [15:0] O_MREQ = 16'h4000;
  localparam logic [15:0] O_PCW  = 16'h2000;
  localparam logic [15:0] O_RW   = 16'h1000;
  localparam logic [15:0] O_ASRC = 16'h0800;
  localparam logic [15:0] O_PCS  = 16'h0400;
  localparam logic [15:0] O_ISRC = 16'h0200;
  localparam logic [15:0] O_M2R  = 16'h0100;
  localparam logic [15:0] O_MW   = 16'h0080;
  localparam logic [15:0] O_RA2  = 16'h0040;
  localparam logic [15:0] O_ALU2 = 16'h0020;
  localparam logic [15:0] O_ALU3 = 16'h0030;
  localparam logic [15:0] O_ERR  = 16'h0008;
  localparam logic [15:0] S_IDLE = 16'd0;
  localparam logic [15:0] S_FET  = 16'd1;
  localparam logic [15:0] S_DEC  = 16'd2;
  localparam logic [15:0] S_EXE  = 16'd3;
  localparam logic [15:0] S_MEM  = 16'd4;
  localparam logic [15:0] S_WB   = 16'd5;
  localparam logic [15:0] S_ERR  = 16'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] inst;
  logic        instValid, cero, memReady;
  logic        instReq, memReq, pcWrite, regWrite, aluSrc, PCSrc, immSrc;
  logic        memToReg, memWrite, ra2Src, err;
  logic [1:0]  aluControl;
  logic [2:0]  state;
  logic [15:0] obs;

  logic [1:0] rd_cls, rd_cond, rd_alu;
  logic       rd_load, rd_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        rstn;
    logic [23:0] inst;
    logic        iv;
    logic        z;
    logic        mr;
    logic [15:0] exp;
  } cyc_t;
  cyc_t sb[$];

  always #5 clk = ~clk;

  mc_control_unit #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .inst(inst), .instValid(instValid), .cero(cero),
    .memReady(memReady), .instReq(instReq), .memReq(memReq), .pcWrite(pcWrite),
    .regWrite(regWrite), .aluSrc(aluSrc), .PCSrc(PCSrc), .immSrc(immSrc),
    .memToReg(memToReg), .memWrite(memWrite), .ra2Src(ra2Src),
    .aluControl(aluControl), .err(err), .state(state)
  );

  cu_decoder u_ref_dec (
    .ir_i(inst), .cls_o(rd_cls), .is_load_o(rd_load), .br_cond_o(rd_cond),
    .alu_op_o(rd_alu), .illegal_o(rd_illegal)
  );

  assign obs = {instReq, memReq, pcWrite, regWrite, aluSrc, PCSrc, immSrc,
                memToReg, memWrite, ra2Src, aluControl, err, state};

  task automatic push(input logic r, input logic [23:0] i, input logic iv,
                      input logic z, input logic mr, input logic [15:0] e);
    cyc_t t;
    t.rstn = r; t.inst = i; t.iv = iv; t.z = z; t.mr = mr; t.exp = e;
    sb.push_back(t);
  endtask

  task automatic push_reset();
    push(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, S_IDLE);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic apply(input cyc_t c, output logic [15:0] o);
    rst = c.rstn; inst = c.inst; instValid = c.iv; cero = c.z; memReady = c.mr;
    #1;
    o = obs;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc_t c; logic [15:0] o; int k = 0;
    push(1'b0, 24'h412_00A, 1'b1, 1'b0, 1'b1, S_IDLE);
    push(1'b0, 24'h412_00A, 1'b1, 1'b0, 1'b1, S_IDLE);
    push(1'b1, 24'h0, 1'b0, 1'b0, 1'b0, S_IDLE);
    push(1'b1, 24'h0, 1'b0, 1'b0, 1'b0, S_FET | O_IREQ);
    push(1'b1, 24'h0, 1'b0, 1'b0, 1'b0, S_FET | O_IREQ);
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c, o); n_checks++;
      if (o !== c.exp) $display("FAIL reset cyc %0d: obs=%h exp=%h", k, o, c.exp);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_dp_imm();
    cyc_t c; logic [15:0] o; int k = 0;
    logic [23:0] i = 24'h41_2_00A;
    push_reset();
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_IDLE);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_FET | O_IREQ);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_DEC);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_EXE | O_ASRC);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_WB | O_RW | O_PCW | O_M2R | O_ASRC);
    push(1'b1, i, 1'b0, 1'b0, 1'b0, S_FET | O_IREQ);
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c, o); n_checks++;
      if (o !== c.exp) $display("FAIL dp_imm cyc %0d: obs=%h exp=%h", k, o, c.exp);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_dp_reg_stall();
    cyc_t c; logic [15:0] o; int k = 0;
    logic [23:0] i = 24'h30_0_000;
    push_reset();
    push(1'b1, i, 1'b0, 1'b0, 1'b0, S_IDLE);
    push(1'b1, i, 1'b0, 1'b0, 1'b0, S_FET | O_IREQ);
    push(1'b1, i, 1'b0, 1'b0, 1'b0, S_FET | O_IREQ);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_FET | O_IREQ);
    push(1'b1, 24'hF00000, 1'b1, 1'b0, 1'b0, S_DEC);
    push(1'b1, 24'hF00000, 1'b1, 1'b0, 1'b0, S_EXE | O_ALU3);
    push(1'b1, 24'hF00000, 1'b1, 1'b0, 1'b0, S_WB | O_RW | O_PCW | O_M2R | O_ALU3);
    push(1'b1, i, 1'b0, 1'b0, 1'b0, S_FET | O_IREQ);
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c, o); n_checks++;
      if (o !== c.exp) $display("FAIL dp_reg cyc %0d: obs=%h exp=%h", k, o, c.exp);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_load();
    cyc_t c; logic [15:0] o; int k = 0;
    logic [23:0] i = 24'h93_4_010;
    push_reset();
    push(1'b1, i, 1'b1, 1'b0, 1'b1, S_IDLE);
    push(1'b1, i, 1'b1, 1'b0, 1'b1, S_FET | O_IREQ);
    push(1'b1, i, 1'b1, 1'b0, 1'b1, S_DEC);
    push(1'b1, i, 1'b1, 1'b0, 1'b1, S_EXE | O_ASRC | O_ISRC);
    for (int w = 0; w < 3; w++)
      push(1'b1, i, 1'b1, 1'b0, 1'b0, S_MEM | O_MREQ | O_ASRC | O_ISRC);
    push(1'b1, i, 1'b1, 1'b0, 1'b1, S_MEM | O_MREQ | O_ASRC | O_ISRC);
    push(1'b1, i, 1'b0, 1'b0, 1'b0, S_WB | O_RW | O_PCW);
    push(1'b1, i, 1'b0, 1'b0, 1'b0, S_FET | O_IREQ);
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c, o); n_checks++;
      if (o !== c.exp) $display("FAIL load cyc %0d: obs=%h exp=%h", k, o, c.exp);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_store_limit();
    cyc_t c; logic [15:0] o; int k = 0;
    logic [23:0] i = 24'h82_5_004;
    logic [15:0] mst = S_MEM | O_MREQ | O_ASRC | O_ISRC | O_MW | O_RA2;
    push_reset();
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_IDLE);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_FET | O_IREQ);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_DEC);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_EXE | O_ASRC | O_ISRC);
    for (int w = 0; w < 15; w++) push(1'b1, i, 1'b1, 1'b0, 1'b0, mst);
    push(1'b1, i, 1'b1, 1'b0, 1'b1, mst | O_PCW);
    // Second store must start its wait count afresh.
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_FET | O_IREQ);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_DEC);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_EXE | O_ASRC | O_ISRC);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, mst);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, mst);
    push(1'b1, i, 1'b1, 1'b0, 1'b1, mst | O_PCW);
    push(1'b1, i, 1'b0, 1'b0, 1'b0, S_FET | O_IREQ);
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c, o); n_checks++;
      if (o !== c.exp) $display("FAIL store_limit cyc %0d: obs=%h exp=%h", k, o, c.exp);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_timeout();
    cyc_t c; logic [15:0] o; int k = 0;
    logic [23:0] i = 24'h82_5_004;
    push_reset();
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_IDLE);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_FET | O_IREQ);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_DEC);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_EXE | O_ASRC | O_ISRC);
    for (int w = 0; w < 16; w++)
      push(1'b1, i, 1'b1, 1'b0, 1'b0, S_MEM | O_MREQ | O_ASRC | O_ISRC | O_MW | O_RA2);
    for (int w = 0; w < 4; w++) push(1'b1, i, 1'b1, 1'b1, 1'b1, S_ERR | O_ERR);
    push_reset();
    push(1'b1, i, 1'b0, 1'b0, 1'b0, S_IDLE);
    push(1'b1, i, 1'b0, 1'b0, 1'b0, S_FET | O_IREQ);
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c, o); n_checks++;
      if (o !== c.exp) $display("FAIL timeout cyc %0d: obs=%h exp=%h", k, o, c.exp);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_branch();
    cyc_t c; logic [15:0] o; int k = 0;
    logic [23:0] beq = 24'hD0_0_005;
    logic [23:0] bne = 24'hE0_0_000;
    logic [23:0] bal = 24'hC0_0_000;
    logic [15:0] bx = S_EXE | O_PCW | O_ASRC | O_ISRC;
    push_reset();
    push(1'b1, beq, 1'b1, 1'b0, 1'b0, S_IDLE);
    push(1'b1, beq, 1'b1, 1'b0, 1'b0, S_FET | O_IREQ);
    push(1'b1, beq, 1'b1, 1'b0, 1'b0, S_DEC);
    push(1'b1, beq, 1'b1, 1'b1, 1'b0, bx | O_PCS);
    push(1'b1, beq, 1'b1, 1'b1, 1'b0, S_FET | O_IREQ);
    push(1'b1, beq, 1'b1, 1'b1, 1'b0, S_DEC);
    push(1'b1, bne, 1'b1, 1'b0, 1'b0, bx);
    push(1'b1, bne, 1'b1, 1'b0, 1'b0, S_FET | O_IREQ);
    push(1'b1, bne, 1'b1, 1'b1, 1'b0, S_DEC);
    push(1'b1, bal, 1'b1, 1'b0, 1'b0, bx | O_PCS);
    push(1'b1, bal, 1'b1, 1'b0, 1'b0, S_FET | O_IREQ);
    push(1'b1, bal, 1'b1, 1'b1, 1'b0, S_DEC);
    push(1'b1, bal, 1'b0, 1'b1, 1'b0, bx | O_PCS);
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c, o); n_checks++;
      if (o !== c.exp) $display("FAIL branch cyc %0d: obs=%h exp=%h", k, o, c.exp);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c; logic [15:0] o; int k = 0;
    logic [23:0] dp = 24'h60_0_000;
    logic [23:0] br = 24'hC0_0_000;
    logic [23:0] ld = 24'h93_4_010;
    logic [23:0] st = 24'h82_5_004;
    push_reset();
    push(1'b1, dp, 1'b1, 1'b0, 1'b1, S_IDLE);
    push(1'b1, dp, 1'b1, 1'b0, 1'b1, S_FET | O_IREQ);
    push(1'b1, br, 1'b1, 1'b0, 1'b1, S_DEC);
    push(1'b1, br, 1'b1, 1'b0, 1'b1, S_EXE | O_ASRC | O_ALU2);
    push(1'b1, br, 1'b1, 1'b0, 1'b1, S_WB | O_RW | O_PCW | O_M2R | O_ASRC | O_ALU2);
    push(1'b1, br, 1'b1, 1'b0, 1'b1, S_FET | O_IREQ);
    push(1'b1, ld, 1'b1, 1'b0, 1'b1, S_DEC);
    push(1'b1, ld, 1'b1, 1'b0, 1'b1, S_EXE | O_PCW | O_PCS | O_ASRC | O_ISRC);
    push(1'b1, ld, 1'b1, 1'b0, 1'b1, S_FET | O_IREQ);
    push(1'b1, st, 1'b1, 1'b0, 1'b1, S_DEC);
    push(1'b1, st, 1'b1, 1'b0, 1'b1, S_EXE | O_ASRC | O_ISRC);
    push(1'b1, st, 1'b1, 1'b0, 1'b1, S_MEM | O_MREQ | O_ASRC | O_ISRC);
    push(1'b1, st, 1'b1, 1'b0, 1'b1, S_WB | O_RW | O_PCW);
    push(1'b1, st, 1'b1, 1'b0, 1'b1, S_FET | O_IREQ);
    push(1'b1, st, 1'b1, 1'b0, 1'b1, S_DEC);
    push(1'b1, st, 1'b1, 1'b0, 1'b1, S_EXE | O_ASRC | O_ISRC);
    push(1'b1, st, 1'b0, 1'b0, 1'b1, S_MEM | O_MREQ | O_ASRC | O_ISRC | O_MW | O_RA2 | O_PCW);
    push(1'b1, st, 1'b0, 1'b0, 1'b1, S_FET | O_IREQ);
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c, o); n_checks++;
      if (o !== c.exp) $display("FAIL back_to_back cyc %0d: obs=%h exp=%h", k, o, c.exp);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_illegal();
    cyc_t c; logic [15:0] o; int k = 0;
    logic [23:0] bad [2] = '{24'hF00000, 24'hA00000};
    inst = 24'hF00000; #1;
    n_checks++;
    if ({rd_illegal, rd_cls} !== 3'b1_11) $display("FAIL dec_F00000: got %b want 111", {rd_illegal, rd_cls});
    else n_pass++;
    inst = 24'hD00005; #1;
    n_checks++;
    if ({rd_illegal, rd_cond} !== 3'b0_01) $display("FAIL dec_D00005: got %b want 001", {rd_illegal, rd_cond});
    else n_pass++;
    inst = 24'h934010; #1;
    n_checks++;
    if ({rd_illegal, rd_load, rd_alu} !== 4'b0_1_01) $display("FAIL dec_934010: got %b want 0101", {rd_illegal, rd_load, rd_alu});
    else n_pass++;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      push_reset();
      push(1'b1, bad[b], 1'b1, 1'b0, 1'b0, S_IDLE);
      push(1'b1, bad[b], 1'b1, 1'b0, 1'b0, S_FET | O_IREQ);
      push(1'b1, bad[b], 1'b1, 1'b0, 1'b1, S_DEC);
      push(1'b1, 24'h41200A, 1'b1, 1'b1, 1'b1, S_ERR | O_ERR);
      push(1'b1, 24'h41200A, 1'b1, 1'b1, 1'b1, S_ERR | O_ERR);
    end
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c, o); n_checks++;
      if (o !== c.exp) $display("FAIL illegal cyc %0d: obs=%h exp=%h", k, o, c.exp);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_reset_mid_mem();
    cyc_t c; logic [15:0] o; int k = 0;
    logic [23:0] i = 24'h93_4_010;
    push_reset();
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_IDLE);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_FET | O_IREQ);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_DEC);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_EXE | O_ASRC | O_ISRC);
    push(1'b1, i, 1'b1, 1'b0, 1'b0, S_MEM | O_MREQ | O_ASRC | O_ISRC);
    push(1'b0, i, 1'b1, 1'b0, 1'b1, S_IDLE);
    push(1'b0, i, 1'b1, 1'b0, 1'b1, S_IDLE);
    push(1'b1, i, 1'b1, 1'b0, 1'b1, S_IDLE);
    push(1'b1, i, 1'b1, 1'b0, 1'b1, S_FET | O_IREQ);
    push(1'b1, i, 1'b1, 1'b0, 1'b1, S_DEC);
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c, o); n_checks++;
      if (o !== c.exp) $display("FAIL reset_mid_mem cyc %0d: obs=%h exp=%h", k, o, c.exp);
      else n_pass++;
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; inst = '0; instValid = 1'b0; cero = 1'b0; memReady = 1'b0;
    @(negedge clk);
    test_reset();
    test_dp_imm();
    test_dp_reg_stall();
    test_load();
    test_store_limit();
    test_timeout();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
